// File: rtl/mby_gmm_pkg.sv
// Shared types and defaults for the GMM pod pointer ring.
package mby_gmm_pkg;

  localparam int MBY_GMM_PTR_W = 20;

  typedef struct packed {
    logic                     valid;
    logic                     dirty;
    logic [MBY_GMM_PTR_W-1:0] ptr;
  } mby_pod_ring_slot_t;

endpackage

// File: rtl/mby_gmm_pod_ptr_fifo.sv
// Small pointer FIFO with occupancy count; push when full and pop when empty are dropped.
module mby_gmm_pod_ptr_fifo
  import mby_gmm_pkg::*;
#(
  parameter int W     = MBY_GMM_PTR_W,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q < CNT_W'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + IDX_W'(1);
    else         wr_d = wr_q;
    if (do_pop)  rd_d = rd_q + IDX_W'(1);
    else         rd_d = rd_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is never reset; stale entries are unreachable once indices clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/mby_gmm_pod_ring_stop.sv
// Pod ring stop: extracts one pointer type into an RX FIFO and inserts locally queued pointers.
module mby_gmm_pod_ring_stop
  import mby_gmm_pkg::*;
#(
  parameter int PTR_W     = MBY_GMM_PTR_W,
  parameter int DEPTH     = 8,
  parameter int EXT_DIRTY = 0,
  parameter int STARVE_TH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ring_in_valid,
  input  logic [PTR_W-1:0]           ring_in_ptr,
  input  logic                       ring_in_dirty,
  output logic                       ring_out_valid,
  output logic [PTR_W-1:0]           ring_out_ptr,
  output logic                       ring_out_dirty,
  input  logic                       ext_en,
  input  logic                       ins_valid,
  output logic                       ins_ready,
  input  logic [PTR_W-1:0]           ins_ptr,
  input  logic                       ins_dirty,
  output logic                       ext_valid,
  input  logic                       ext_ready,
  output logic [PTR_W-1:0]           ext_ptr,
  output logic [$clog2(DEPTH+1)-1:0] tx_cnt,
  output logic [$clog2(DEPTH+1)-1:0] rx_cnt,
  output logic                       starve
);

  localparam int   CNT_W   = $clog2(DEPTH + 1);
  localparam int   SCNT_W  = $clog2(STARVE_TH + 1);
  localparam logic EXT_BIT = (EXT_DIRTY != 0);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [PTR_W-1:0] ptr;
  } slot_t;

  slot_t             slot_q, slot_d;
  logic [PTR_W:0]    tx_head;
  logic              ext_hit, slot_free, ins_fire;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              starve_q;

  assign ext_hit   = ring_in_valid && (ring_in_dirty == EXT_BIT) && ext_en
                     && (rx_cnt < CNT_W'(DEPTH));
  assign slot_free = !ring_in_valid || ext_hit;
  assign ins_fire  = slot_free && (tx_cnt != '0);
  assign ins_ready = (tx_cnt < CNT_W'(DEPTH));
  assign ext_valid = (rx_cnt != '0);

  mby_gmm_pod_ptr_fifo #(.W(PTR_W + 1), .DEPTH(DEPTH)) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ins_valid && ins_ready),
    .push_data_i ({ins_dirty, ins_ptr}),
    .pop_i       (ins_fire),
    .head_o      (tx_head),
    .count_o     (tx_cnt)
  );

  mby_gmm_pod_ptr_fifo #(.W(PTR_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ext_hit),
    .push_data_i (ring_in_ptr),
    .pop_i       (ext_valid && ext_ready),
    .head_o      (ext_ptr),
    .count_o     (rx_cnt)
  );

  // Outgoing slot: insertion wins a freed slot, otherwise pass or empty it.
  always_comb begin
    slot_d = '0;
    if (ins_fire) begin
      slot_d.valid = 1'b1;
      slot_d.dirty = tx_head[PTR_W];
      slot_d.ptr   = tx_head[PTR_W-1:0];
    end else if (ext_hit) begin
      slot_d = '0;
    end else begin
      slot_d.valid = ring_in_valid;
      slot_d.dirty = ring_in_dirty;
      slot_d.ptr   = ring_in_ptr;
    end
  end

  // Starvation counter saturates at the threshold.
  always_comb begin
    scnt_d = scnt_q;
    if (ins_fire || (tx_cnt == '0)) scnt_d = '0;
    else if (scnt_q < SCNT_W'(STARVE_TH)) scnt_d = scnt_q + SCNT_W'(1);
    else scnt_d = scnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      scnt_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      scnt_q   <= scnt_d;
      starve_q <= (scnt_d == SCNT_W'(STARVE_TH));
    end
  end

  assign ring_out_valid = slot_q.valid;
  assign ring_out_dirty = slot_q.dirty;
  assign ring_out_ptr   = slot_q.ptr;
  assign starve         = starve_q;

endmodule

// File: tb/tb_mby_gmm_pod_ring_stop.sv
// Directed bench for the pod ring stop with default parameters.
module tb_mby_gmm_pod_ring_stop;

  localparam int PTR_W = 20;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ring_in_valid, ring_in_dirty;
  logic [PTR_W-1:0] ring_in_ptr;
  logic             ring_out_valid, ring_out_dirty;
  logic [PTR_W-1:0] ring_out_ptr;
  logic             ext_en, ins_valid, ins_ready, ins_dirty;
  logic [PTR_W-1:0] ins_ptr;
  logic             ext_valid, ext_ready;
  logic [PTR_W-1:0] ext_ptr;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             starve;

  int n_checks = 0;
  int n_fail   = 0;

  mby_gmm_pod_ring_stop #(.PTR_W(PTR_W), .DEPTH(DEPTH), .EXT_DIRTY(0), .STARVE_TH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ring_in_valid(ring_in_valid), .ring_in_ptr(ring_in_ptr), .ring_in_dirty(ring_in_dirty),
    .ring_out_valid(ring_out_valid), .ring_out_ptr(ring_out_ptr), .ring_out_dirty(ring_out_dirty),
    .ext_en(ext_en), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_ptr(ins_ptr),
    .ins_dirty(ins_dirty), .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_ptr(ext_ptr),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ring_in_valid = 1'b0; ring_in_dirty = 1'b0; ring_in_ptr = '0;
    ext_en = 1'b0; ins_valid = 1'b0; ins_ptr = '0; ins_dirty = 1'b0; ext_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    n_checks++;
    if ({ring_out_valid, ring_out_dirty, ring_out_ptr, ext_valid, tx_cnt, rx_cnt, starve} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%b p=%h ev=%b tx=%0d rx=%0d st=%b, expected all 0",
               ring_out_valid, ring_out_dirty, ring_out_ptr, ext_valid, tx_cnt, rx_cnt, starve);
    end
    ring_in_valid = 1'b1; ring_in_ptr = 20'h00123; ext_en = 1'b1; ins_valid = 1'b1; ins_ptr = 20'h00321;
    tick(); tick();
    n_checks++;
    if ({ring_out_valid, tx_cnt, rx_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_ignores_inputs: got v=%b tx=%0d rx=%0d, expected 0 0 0", ring_out_valid, tx_cnt, rx_cnt);
    end
    idle();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (ring_out_valid !== 1'b0 || tx_cnt !== 4'd0 || ins_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b tx=%0d rdy=%b, expected 0 0 1", ring_out_valid, tx_cnt, ins_ready);
    end
  endtask

  task automatic test_pass_through();
    ring_in_valid = 1'b1; ring_in_ptr = 20'h00ABC; ring_in_dirty = 1'b1;
    tick();
    n_checks++;
    if (ring_out_valid !== 1'b1 || ring_out_ptr !== 20'h00ABC || ring_out_dirty !== 1'b1 || rx_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL pass_through: got v=%b p=%h d=%b rx=%0d, expected 1 00abc 1 0",
               ring_out_valid, ring_out_ptr, ring_out_dirty, rx_cnt);
    end
    idle();
    tick();
    n_checks++;
    if (ring_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_empty: got v=%b, expected 0", ring_out_valid);
    end
  endtask

  task automatic test_extract();
    ext_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ring_in_valid = 1'b1; ring_in_dirty = 1'b0; ring_in_ptr = PTR_W'(i);
      tick();
      n_checks++;
      if (ring_out_valid !== 1'b0 || rx_cnt !== CNT_W'(i)) begin
        n_fail++;
        $display("FAIL extract_%0d: got v=%b rx=%0d, expected 0 %0d", i, ring_out_valid, rx_cnt, i);
      end
    end
    idle();
    ext_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (ext_valid !== 1'b1 || ext_ptr !== PTR_W'(i)) begin
        n_fail++;
        $display("FAIL extract_pop_%0d: got ev=%b p=%h, expected 1 %h", i, ext_valid, ext_ptr, i);
      end
      tick();
    end
    ext_ready = 1'b0;
    n_checks++;
    if (ext_valid !== 1'b0 || rx_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL extract_drained: got ev=%b rx=%0d, expected 0 0", ext_valid, rx_cnt);
    end
  endtask

  task automatic test_rx_full();
    ext_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ring_in_valid = 1'b1; ring_in_dirty = 1'b0; ring_in_ptr = PTR_W'(32'h100 + i);
      tick();
      n_checks++;
      if (i < 8 && (ring_out_valid !== 1'b0 || rx_cnt !== CNT_W'(i + 1))) begin
        n_fail++;
        $display("FAIL rx_fill_%0d: got v=%b rx=%0d, expected 0 %0d", i, ring_out_valid, rx_cnt, i + 1);
      end else if (i >= 8 && (ring_out_valid !== 1'b1 || ring_out_ptr !== PTR_W'(32'h100 + i) || rx_cnt !== 4'd8)) begin
        n_fail++;
        $display("FAIL rx_full_pass_%0d: got v=%b p=%h rx=%0d, expected 1 %h 8",
                 i, ring_out_valid, ring_out_ptr, rx_cnt, 32'h100 + i);
      end
    end
    ring_in_ptr = 20'h00200; ext_ready = 1'b1;
    tick();
    n_checks++;
    if (ring_out_valid !== 1'b1 || ring_out_ptr !== 20'h00200 || rx_cnt !== 4'd7) begin
      n_fail++;
      $display("FAIL rx_pop_while_full: got v=%b p=%h rx=%0d, expected 1 00200 7", ring_out_valid, ring_out_ptr, rx_cnt);
    end
    ring_in_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (ext_ptr !== PTR_W'(32'h100 + i)) begin
        n_fail++;
        $display("FAIL rx_order_%0d: got %h, expected %h", i, ext_ptr, 32'h100 + i);
      end
      tick();
    end
    idle();
    n_checks++;
    if (rx_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL rx_drained: got rx=%0d, expected 0", rx_cnt);
    end
  endtask

  task automatic test_swap();
    ins_valid = 1'b1; ins_ptr = 20'h00055; ins_dirty = 1'b1;
    tick();
    n_checks++;
    if (tx_cnt !== 4'd1 || ring_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_no_bypass: got tx=%0d v=%b, expected 1 0", tx_cnt, ring_out_valid);
    end
    ins_valid = 1'b0;
    ext_en = 1'b1; ring_in_valid = 1'b1; ring_in_dirty = 1'b0; ring_in_ptr = 20'h00077;
    tick();
    n_checks++;
    if (ring_out_valid !== 1'b1 || ring_out_ptr !== 20'h00055 || ring_out_dirty !== 1'b1 ||
        tx_cnt !== 4'd0 || rx_cnt !== 4'd1 || ext_ptr !== 20'h00077) begin
      n_fail++;
      $display("FAIL swap: got v=%b p=%h d=%b tx=%0d rx=%0d ep=%h, expected 1 00055 1 0 1 00077",
               ring_out_valid, ring_out_ptr, ring_out_dirty, tx_cnt, rx_cnt, ext_ptr);
    end
    idle();
    ext_ready = 1'b1;
    tick();
    ext_ready = 1'b0;
  endtask

  task automatic test_starve();
    ext_en = 1'b1; ring_in_valid = 1'b1; ring_in_dirty = 1'b1; ring_in_ptr = 20'h00300;
    ins_valid = 1'b1; ins_ptr = 20'h00066; ins_dirty = 1'b0;
    tick();
    ins_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 15 || k == 16 || k == 17) begin
        n_checks++;
        if (starve !== (k >= 16) || ring_out_ptr !== 20'h00300 || tx_cnt !== 4'd1) begin
          n_fail++;
          $display("FAIL starve_cycle_%0d: got st=%b p=%h tx=%0d, expected %b 00300 1",
                   k, starve, ring_out_ptr, tx_cnt, (k >= 16));
        end
      end
    end
    ring_in_valid = 1'b0;
    tick();
    n_checks++;
    if (ring_out_valid !== 1'b1 || ring_out_ptr !== 20'h00066 || ring_out_dirty !== 1'b0 ||
        tx_cnt !== 4'd0 || starve !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_release: got v=%b p=%h d=%b tx=%0d st=%b, expected 1 00066 0 0 0",
               ring_out_valid, ring_out_ptr, ring_out_dirty, tx_cnt, starve);
    end
    idle();
  endtask

  task automatic test_tx_full();
    ring_in_valid = 1'b1; ring_in_dirty = 1'b1; ring_in_ptr = 20'h00400;
    ins_valid = 1'b1; ins_dirty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ins_ptr = PTR_W'(32'h10 + i);
      tick();
    end
    n_checks++;
    if (tx_cnt !== 4'd8 || ins_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_full: got tx=%0d rdy=%b, expected 8 0", tx_cnt, ins_ready);
    end
    ins_ptr = 20'h000FF;
    tick();
    n_checks++;
    if (tx_cnt !== 4'd8) begin
      n_fail++;
      $display("FAIL tx_overflow: got tx=%0d, expected 8", tx_cnt);
    end
    ins_valid = 1'b0; ring_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (ring_out_valid !== 1'b1 || ring_out_ptr !== PTR_W'(32'h10 + i) || ring_out_dirty !== 1'b1) begin
        n_fail++;
        $display("FAIL tx_order_%0d: got v=%b p=%h d=%b, expected 1 %h 1",
                 i, ring_out_valid, ring_out_ptr, ring_out_dirty, 32'h10 + i);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    ext_en = 1'b1; ring_in_valid = 1'b1; ring_in_dirty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ring_in_ptr = PTR_W'(32'h500 + i);
      tick();
    end
    ring_in_dirty = 1'b1; ring_in_ptr = 20'h00600; ins_valid = 1'b1; ins_dirty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ins_ptr = PTR_W'(32'h20 + i);
      tick();
    end
    ins_valid = 1'b0;
    n_checks++;
    if (tx_cnt !== 4'd3 || rx_cnt !== 4'd5 || ring_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: got tx=%0d rx=%0d v=%b, expected 3 5 1", tx_cnt, rx_cnt, ring_out_valid);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({ring_out_valid, ring_out_dirty, ring_out_ptr, ext_valid, tx_cnt, rx_cnt, starve} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got v=%b d=%b p=%h ev=%b tx=%0d rx=%0d st=%b, expected all 0",
               ring_out_valid, ring_out_dirty, ring_out_ptr, ext_valid, tx_cnt, rx_cnt, starve);
    end
    ins_valid = 1'b1; ring_in_dirty = 1'b0; ext_ready = 1'b1;
    tick(); tick();
    idle();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (tx_cnt !== 4'd0 || rx_cnt !== 4'd0 || ring_out_valid !== 1'b0 || ext_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after_release: got tx=%0d rx=%0d v=%b ev=%b, expected 0 0 0 0",
               tx_cnt, rx_cnt, ring_out_valid, ext_valid);
    end
    ins_valid = 1'b1; ins_ptr = 20'h00ACE; ins_dirty = 1'b1;
    tick();
    ins_valid = 1'b0;
    tick();
    n_checks++;
    if (ring_out_valid !== 1'b1 || ring_out_ptr !== 20'h00ACE || tx_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL cold_start_insert: got v=%b p=%h tx=%0d, expected 1 00ace 0",
               ring_out_valid, ring_out_ptr, tx_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_extract();
    test_rx_full();
    test_swap();
    test_starve();
    test_tx_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mby_gmm_pod_ring_stop.md
MBY_GMM_POD_RING_STOP -- requirements
Module: mby_gmm_pod_ring_stop

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PTR_W, 20, pointer width.
- DEPTH, 8, entries per local FIFO; power of two, at least 2.
- EXT_DIRTY, 0, pointer type this stop extracts (0 = free, 1 = dirty).
- STARVE_TH, 16, insertion-starvation threshold in cycles.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- ring_in_valid, in, 1, upstream slot occupied.
- ring_in_ptr, in, PTR_W, upstream pointer.
- ring_in_dirty, in, 1, upstream pointer type.
- ring_out_valid, out, 1, downstream slot occupied.
- ring_out_ptr, out, PTR_W, downstream pointer.
- ring_out_dirty, out, 1, downstream pointer type.
- ext_en, in, 1, extraction enable.
- ins_valid, in, 1, local insert request.
- ins_ready, out, 1, TX FIFO can accept.
- ins_ptr, in, PTR_W, pointer to insert.
- ins_dirty, in, 1, type of pointer to insert.
- ext_valid, out, 1, RX FIFO holds a pointer.
- ext_ready, in, 1, local consumer accepts.
- ext_ptr, out, PTR_W, RX FIFO head pointer.
- tx_cnt, out, $clog2(DEPTH+1), TX FIFO occupancy.
- rx_cnt, out, $clog2(DEPTH+1), RX FIFO occupancy.
- starve, out, 1, insertion starvation flag.

Function
REQ-003 The ring path SHALL be one register stage: the slot presented at cycle N appears, after any extraction and insertion, on ring_out_* at cycle N+1.
REQ-004 A slot SHALL be extracted when all of these hold: ring_in_valid=1, ring_in_dirty==EXT_DIRTY, ext_en=1, and rx_cnt<DEPTH at the start of the cycle. A pop in the same cycle SHALL NOT create room for that cycle's extraction.
REQ-005 An extracted pointer SHALL be written into the RX FIFO, and the outgoing slot SHALL become empty unless REQ-006 fills it.
REQ-006 When the slot is empty after REQ-004/005 and tx_cnt>0, the TX FIFO head SHALL be inserted into the outgoing slot, with ring_out_dirty taken from the stored ins_dirty; that entry SHALL be popped.
REQ-007 Extraction and insertion in the same cycle SHALL both occur.
REQ-008 A valid slot that is not extracted SHALL pass through unchanged; an empty slot with tx_cnt==0 SHALL pass through empty. ring_out_ptr is don't-care when ring_out_valid=0.
REQ-009 ins_ready SHALL equal (tx_cnt<DEPTH), and a push SHALL occur on ins_valid&&ins_ready. A pointer pushed at cycle N SHALL NOT be insertable before cycle N+1 (no bypass).
REQ-010 ext_valid SHALL equal (rx_cnt>0), with ext_ptr the RX FIFO head; a pop SHALL occur on ext_valid&&ext_ready. An extraction into an empty RX FIFO SHALL raise ext_valid at cycle N+1.
REQ-011 A simultaneous push and pop on either FIFO SHALL leave its count unchanged. Read and write indices SHALL wrap modulo DEPTH. Counts SHALL never exceed DEPTH or underflow.
REQ-012 The starvation counter SHALL behave as follows:
- It increments in every cycle with tx_cnt>0 and no insertion.
- It clears on an insertion or when tx_cnt==0.
- It saturates at STARVE_TH.
- starve SHALL be registered and equal 1 when counter==STARVE_TH.
REQ-013 Pushes with ins_dirty!=EXT_DIRTY SHALL be accepted; a pointer of the extracted type, once inserted, SHALL pass through other stops unchanged.

Reset
REQ-014 While rst_n=0, regardless of clk, these outputs SHALL be forced to zero: ring_out_valid, ring_out_dirty, ring_out_ptr, ext_valid, tx_cnt, rx_cnt, starve. The starvation counter and all FIFO indices SHALL also be zero.
REQ-015 FIFO storage SHALL NOT require reset. Pushes, pops and ring slots presented while rst_n=0 SHALL be ignored.
REQ-016 A reset asserted mid-operation SHALL discard all FIFO contents and the in-flight slot. The first cycle after deassertion SHALL behave as a cold start.

Structure
REQ-017 The following SHALL live in mby_gmm_pkg: the ring slot struct mby_pod_ring_slot_t (valid, dirty, ptr) and the PTR_W default constant.
REQ-018 The two FIFOs SHALL be instances of a single sub-module, mby_gmm_pod_ptr_fifo, parametrised by width and DEPTH, exposing count, push/pop, and head.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Pass-through: ext_en=0, valid slot ptr=0x00ABC, dirty=1 -> the same slot on ring_out one cycle later, and rx_cnt stays 0.
- Extract: EXT_DIRTY=0, ext_en=1, four free slots 0x1..0x4 -> ring_out_valid=0 for four cycles, rx_cnt=4, and ext_ptr pops 0x1..0x4 in order.
- RX full: DEPTH=8, ext_ready=0, ten matching slots -> first eight extracted, slots 9 and 10 pass through with rx_cnt=8, and no extraction in the cycle an entry is popped while full.
- Swap: TX holds 0x55 and a matching slot 0x77 arrives -> 0x77 is extracted and ring_out carries 0x55 in the same cycle, tx_cnt 1->0, rx_cnt 0->1.
- Starvation: STARVE_TH=16, tx_cnt=1, ring all valid non-matching -> starve=1 after 16 cycles; one empty slot -> insertion, and starve=0 the next cycle.
- Reset mid-run: rst_n pulled low with tx_cnt=3 and rx_cnt=5 -> all outputs 0 immediately, and counts stay 0 after release.
